fifo_rd_stream: RTL

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

---
 rtl/fifo_rd_stream_if.sv | 24 ++
 rtl/fifo_rd_stream.sv | 96 +++++++++
 2 files changed

// File: rtl/fifo_rd_stream_if.sv
// FIFO read-side and downstream stream signals of fifo_rd_stream.
// master is the streaming engine, slave is the FIFO/sink side.
interface fifo_rd_stream_if #(
    parameter int WIDTH = 8,
    parameter int PTR   = 4
);
    logic             fifo_rden;
    logic [WIDTH-1:0] fifo_dataout;
    logic             fifo_rdempty;
    logic [PTR:0]     fifo_rdusedw;
    logic             m_ready;
    logic             m_valid;
    logic [WIDTH-1:0] m_data;

    modport master (
        output fifo_rden, m_valid, m_data,
        input  fifo_dataout, fifo_rdempty, fifo_rdusedw, m_ready
    );

    modport slave (
        input  fifo_rden, m_valid, m_data,
        output fifo_dataout, fifo_rdempty, fifo_rdusedw, m_ready
    );
endinterface

// File: rtl/fifo_rd_stream.sv
// Pulls words from a show-ahead-less FIFO into a 3-deep skid buffer
// and streams them out with valid/ready; bursts start at a fill level.
module fifo_rd_stream #(
    parameter int WIDTH     = 8,
    parameter int PTR       = 4,
    parameter int START_LVL = 4
) (
    input  logic              rdclk,
    input  logic              reset,
    fifo_rd_stream_if.master  bus,
    input  logic              flush_req,
    output logic              flush_done,
    output logic              busy,
    output logic [15:0]       word_cnt
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] buf_q [3];
    logic [WIDTH-1:0] buf_n [3];
    logic [1:0]       occ, occ_n, idx;
    logic [2:0]       lvl, occ_w;
    logic             inflight, pop, rden, fifo_idle;

    // lvl counts words held plus the one already requested
    assign lvl   = {1'b0, occ} + {2'b0, inflight};
    assign occ_w = lvl - {2'b0, pop};
    assign occ_n = occ_w[1:0];
    assign idx   = occ - {1'b0, pop};
    assign pop   = (occ != 2'd0) & bus.m_ready;
    assign rden  = ((state == RUN) | (state == DRAIN)) &
                   !bus.fifo_rdempty & (lvl < 3'd3) & !reset;
    assign fifo_idle = bus.fifo_rdempty & !inflight;

    assign bus.fifo_rden = rden;
    assign bus.m_valid   = (occ != 2'd0);
    assign bus.m_data    = buf_q[0];
    assign busy          = (state != IDLE);

    always_comb begin
        buf_n = buf_q;
        if (pop) begin
            buf_n[0] = buf_q[1];
            buf_n[1] = buf_q[2];
        end
        if (inflight) begin
            if (idx == 2'd0)      buf_n[0] = bus.fifo_dataout;
            else if (idx == 2'd1) buf_n[1] = bus.fifo_dataout;
            else                  buf_n[2] = bus.fifo_dataout;
        end
    end

    always_comb begin
        state_n    = state;
        flush_done = 1'b0;
        unique case (state)
            IDLE: begin
                if (flush_req)
                    state_n = DRAIN;
                else if (32'(bus.fifo_rdusedw) >= START_LVL)
                    state_n = RUN;
            end
            RUN: begin
                if (flush_req)
                    state_n = DRAIN;
                else if (fifo_idle)
                    state_n = IDLE;
            end
            DRAIN: begin
                // a repeated flush_req here changes nothing
                if (fifo_idle && occ == 2'd0) begin
                    state_n    = IDLE;
                    flush_done = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge rdclk) begin
        if (reset) begin
            state    <= IDLE;
            occ      <= 2'd0;
            inflight <= 1'b0;
            word_cnt <= 16'd0;
            buf_q    <= '{default: '0};
        end else begin
            state    <= state_n;
            occ      <= occ_n;
            inflight <= rden;
            buf_q    <= buf_n;
            if (pop)
                word_cnt <= word_cnt + 16'd1;
        end
    end
endmodule
